// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter that shares one single-port synchronous memory between
// NUM_CLIENTS request/grant clients, with an optional limit on grant tenure.
module memory_arbiter_rr #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_HOLD    = 16
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NUM_CLIENTS-1:0]             requestingMemory,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]  clientAddress,
    input  logic [NUM_CLIENTS-1:0]             clientReadWrite,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]  clientWriteData,
    output logic [NUM_CLIENTS-1:0]             grantedAccess,
    output logic [ADDR_WIDTH-1:0]              memAddress,
    output logic                               memReadWrite,
    output logic                               memWriteEnable,
    output logic [DATA_WIDTH-1:0]              memWriteData,
    output logic                               busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]     owner,
    output logic                               timeoutPulse
);

    localparam int OW = $clog2(NUM_CLIENTS);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [OW-1:0] LAST_CLIENT = OW'(NUM_CLIENTS - 1);
    localparam logic [HW-1:0] HOLD_LIMIT  = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]             state;
    logic [OW-1:0]          ptr;
    logic [HW-1:0]          hold_count;
    logic                   sel_valid;
    logic [OW-1:0]          sel_index;
    logic [NUM_CLIENTS-1:0] sel_onehot;
    logic                   owner_req;
    logic                   hold_expired;
    logic [OW-1:0]          owner_next;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign addr_arr[g]  = clientAddress[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = clientWriteData[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts at ptr and wraps, so the first hit is the highest-priority requester.
    always_comb begin
        sel_valid = 1'b0;
        sel_index = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            int            sum;
            logic [OW-1:0] cand;
            sum = int'(ptr) + i;
            if (sum >= NUM_CLIENTS) begin
                sum = sum - NUM_CLIENTS;
            end
            cand = OW'(sum);
            if (!sel_valid && requestingMemory[cand]) begin
                sel_valid = 1'b1;
                sel_index = cand;
            end
        end
    end

    assign sel_onehot   = NUM_CLIENTS'(1) << sel_index;
    assign owner_req    = requestingMemory[owner];
    assign hold_expired = (MAX_HOLD != 0) && (hold_count == HOLD_LIMIT);
    assign owner_next   = (owner == LAST_CLIENT) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            grantedAccess <= '0;
            busy          <= 1'b0;
            owner         <= '0;
            ptr           <= '0;
            hold_count    <= '0;
            timeoutPulse  <= 1'b0;
        end else begin
            timeoutPulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state         <= BUSY;
                        grantedAccess <= sel_onehot;
                        owner         <= sel_index;
                        busy          <= 1'b1;
                        hold_count    <= '0;
                    end
                end
                BUSY: begin
                    if (hold_count != '1) begin
                        hold_count <= hold_count + 1'b1;
                    end
                    // A still-requesting owner can only be leaving because its hold limit expired.
                    if (!owner_req || hold_expired) begin
                        state         <= IDLE;
                        grantedAccess <= '0;
                        busy          <= 1'b0;
                        ptr           <= owner_next;
                        timeoutPulse  <= owner_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        memAddress     = '0;
        memReadWrite   = 1'b1;
        memWriteData   = '0;
        memWriteEnable = 1'b0;
        if (busy) begin
            memAddress     = addr_arr[owner];
            memReadWrite   = clientReadWrite[owner];
            memWriteData   = wdata_arr[owner];
            memWriteEnable = owner_req & ~clientReadWrite[owner];
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Self-checking bench for memory_arbiter_rr: directed protocol scenarios plus
// randomized traffic compared against a behavioural arbitration model.
`timescale 1ns/1ps
module tb_memory_arbiter_rr;

    localparam int N        = 4;
    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn;
    logic [N-1:0]    req;
    logic [AW-1:0]   addr_c  [N];
    logic [N-1:0]    rw_c;
    logic [DW-1:0]   wdata_c [N];
    logic [N*AW-1:0] clientAddress;
    logic [N*DW-1:0] clientWriteData;

    logic [N-1:0]    grantedAccess;
    logic [AW-1:0]   memAddress;
    logic            memReadWrite;
    logic            memWriteEnable;
    logic [DW-1:0]   memWriteData;
    logic            busy;
    logic [1:0]      owner;
    logic            timeoutPulse;

    int checks = 0;
    int errors = 0;

    always_comb begin
        clientAddress   = '0;
        clientWriteData = '0;
        for (int i = 0; i < N; i++) begin
            clientAddress[i*AW +: AW]   = addr_c[i];
            clientWriteData[i*DW +: DW] = wdata_c[i];
        end
    end

    memory_arbiter_rr #(
        .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .resetn(resetn),
        .requestingMemory(req), .clientAddress(clientAddress),
        .clientReadWrite(rw_c), .clientWriteData(clientWriteData),
        .grantedAccess(grantedAccess), .memAddress(memAddress),
        .memReadWrite(memReadWrite), .memWriteEnable(memWriteEnable),
        .memWriteData(memWriteData), .busy(busy), .owner(owner),
        .timeoutPulse(timeoutPulse)
    );

    // Single-port memory with one cycle of read latency.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rdata;
    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddress] <= memWriteData;
        rdata <= mem[memAddress];
    end

    // Reference: who holds the memory, for how many cycles, and whose turn is next.
    int m_busy = 0, m_owner = 0, m_ptr = 0, m_tenure = 0, m_tpulse = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_tenure = 0; m_tpulse = 0;
        end else begin
            m_tpulse = 0;
            if (m_busy != 0) begin
                m_tenure = m_tenure + 1;
                if (req[m_owner] == 1'b0) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end else if (MAX_HOLD != 0 && m_tenure >= MAX_HOLD) begin
                    m_busy   = 0;
                    m_ptr    = (m_owner + 1) % N;
                    m_tpulse = 1;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_busy == 0 && req[(m_ptr + k) % N]) begin
                        m_busy   = 1;
                        m_owner  = (m_ptr + k) % N;
                        m_tenure = 0;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        resetn = 1'b0;
        req    = '0;
        rw_c   = '1;
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input int c, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            next_cycle();
            ok = grantedAccess[c];
        end
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        checks++; if (grantedAccess !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grantedAccess); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
        checks++; if (timeoutPulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeoutPulse); end
        checks++; if ({memAddress, memReadWrite, memWriteEnable, memWriteData} !== {8'h00, 1'b1, 1'b0, 32'h0})
            begin errors++; $display("[TB] FAIL reset_memport: got a=%h rw=%b we=%b d=%h expected 00/1/0/0", memAddress, memReadWrite, memWriteEnable, memWriteData); end
    endtask

    task automatic test_single_client();
        do_reset();
        req[2] = 1'b1; addr_c[2] = 8'h18; rw_c[2] = 1'b1;
        sample();
        checks++; if (grantedAccess !== 4'b0000) begin errors++; $display("[TB] FAIL single_request_cycle: got %b expected 0000", grantedAccess); end
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0100", grantedAccess); end
        checks++; if ({busy, owner} !== {1'b1, 2'd2}) begin errors++; $display("[TB] FAIL single_owner: got busy=%b owner=%0d expected 1/2", busy, owner); end
        checks++; if ({memAddress, memReadWrite, memWriteEnable} !== {8'h18, 1'b1, 1'b0})
            begin errors++; $display("[TB] FAIL single_memport: got a=%h rw=%b we=%b expected 18/1/0", memAddress, memReadWrite, memWriteEnable); end
        next_cycle(); req[2] = 1'b0; sample();
        checks++; if (grantedAccess !== 4'b0100) begin errors++; $display("[TB] FAIL single_release_lag: got %b expected 0100", grantedAccess); end
        next_cycle(); sample();
        checks++; if ({grantedAccess, busy, memAddress} !== {4'b0000, 1'b0, 8'h00})
            begin errors++; $display("[TB] FAIL single_released: got g=%b busy=%b a=%h expected 0000/0/00", grantedAccess, busy, memAddress); end
        req = 4'b1001;
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b1000) begin errors++; $display("[TB] FAIL single_ptr_advanced: got %b expected 1000", grantedAccess); end
        req = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_atomic_increment();
        bit            ok;
        logic [DW-1:0] captured;
        do_reset();
        req[0] = 1'b1; addr_c[0] = 8'h18; rw_c[0] = 1'b0; wdata_c[0] = 32'd41;
        wait_grant(0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL atomic_preload_grant: got no grant expected grant within 10 cycles"); end
        sample();
        checks++; if ({memWriteEnable, memWriteData} !== {1'b1, 32'd41}) begin errors++; $display("[TB] FAIL atomic_preload_write: got we=%b d=%0d expected 1/41", memWriteEnable, memWriteData); end
        next_cycle(); req[0] = 1'b0; rw_c[0] = 1'b1;
        next_cycle(); next_cycle();
        req[0] = 1'b1;
        wait_grant(0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL atomic_grant: got no grant expected grant within 10 cycles"); end
        sample();
        checks++; if ({memAddress, memReadWrite, memWriteEnable} !== {8'h18, 1'b1, 1'b0})
            begin errors++; $display("[TB] FAIL atomic_read_cycle: got a=%h rw=%b we=%b expected 18/1/0", memAddress, memReadWrite, memWriteEnable); end
        next_cycle(); captured = rdata; sample();
        checks++; if (captured !== 32'd41) begin errors++; $display("[TB] FAIL atomic_read_data: got %0d expected 41", captured); end
        checks++; if (memWriteEnable !== 1'b0) begin errors++; $display("[TB] FAIL atomic_no_early_write: got %b expected 0", memWriteEnable); end
        next_cycle(); rw_c[0] = 1'b0; wdata_c[0] = captured + 1; sample();
        checks++; if ({memWriteEnable, memWriteData} !== {1'b1, 32'd42}) begin errors++; $display("[TB] FAIL atomic_write: got we=%b d=%0d expected 1/42", memWriteEnable, memWriteData); end
        next_cycle(); req[0] = 1'b0; rw_c[0] = 1'b1; sample();
        checks++; if ({grantedAccess, memWriteEnable} !== {4'b0001, 1'b0}) begin errors++; $display("[TB] FAIL atomic_drop_cycle: got g=%b we=%b expected 0001/0", grantedAccess, memWriteEnable); end
        next_cycle(); sample();
        checks++; if ({grantedAccess, busy} !== {4'b0000, 1'b0}) begin errors++; $display("[TB] FAIL atomic_idle: got g=%b busy=%b expected 0000/0", grantedAccess, busy); end
        req[0] = 1'b1;
        wait_grant(0, ok);
        next_cycle();
        checks++; if (rdata !== 32'd42) begin errors++; $display("[TB] FAIL atomic_readback: got %0d expected 42", rdata); end
        req = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_round_robin_all();
        int           cnt [N];
        logic [N-1:0] exp_g;
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        req = '1; rw_c = '1;
        for (int k = 1; k <= 19; k++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                cnt[i] = grantedAccess[i] ? cnt[i] + 1 : 0;
                req[i] = !(grantedAccess[i] && cnt[i] == 3);
            end
            sample();
            exp_g = ((k - 1) % 4 == 3) ? 4'b0000 : (4'b0001 << (((k - 1) / 4) % N));
            checks++; if (grantedAccess !== exp_g) begin errors++; $display("[TB] FAIL rr_order cycle %0d: got %b expected %b", k, grantedAccess, exp_g); end
        end
        req = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 4'b0010;
        next_cycle(); req = 4'b1010; sample();
        checks++; if (grantedAccess !== 4'b0010) begin errors++; $display("[TB] FAIL np_first: got %b expected 0010", grantedAccess); end
        next_cycle(); req = 4'b1000; sample();
        checks++; if (grantedAccess !== 4'b0010) begin errors++; $display("[TB] FAIL np_no_preempt: got %b expected 0010", grantedAccess); end
        next_cycle(); req = 4'b1010; sample();
        checks++; if (grantedAccess !== 4'b0000) begin errors++; $display("[TB] FAIL np_gap: got %b expected 0000", grantedAccess); end
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b1000) begin errors++; $display("[TB] FAIL np_waiter_first: got %b expected 1000", grantedAccess); end
        next_cycle(); req = 4'b0010; sample();
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b0000) begin errors++; $display("[TB] FAIL np_gap2: got %b expected 0000", grantedAccess); end
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b0010) begin errors++; $display("[TB] FAIL np_rerequest: got %b expected 0010", grantedAccess); end
        req = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp_g;
        logic         exp_p;
        do_reset();
        req = 4'b0011;
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            if (k == 18) req[1] = 1'b0;
            sample();
            exp_p = (k == 17 || k == 36);
            if (k <= 16 || (k >= 20 && k <= 35) || k >= 37) exp_g = 4'b0001;
            else if (k == 18) exp_g = 4'b0010;
            else exp_g = 4'b0000;
            checks++; if ({grantedAccess, timeoutPulse} !== {exp_g, exp_p})
                begin errors++; $display("[TB] FAIL timeout cycle %0d: got g=%b p=%b expected %b/%b", k, grantedAccess, timeoutPulse, exp_g, exp_p); end
        end
        req = '0;
        next_cycle(); next_cycle();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req = 4'b0010;
        next_cycle(); req = 4'b0000;
        next_cycle();
        req = 4'b0100; addr_c[2] = 8'h30; rw_c[2] = 1'b1; wdata_c[2] = 32'd77;
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b0100) begin errors++; $display("[TB] FAIL rmw_grant: got %b expected 0100", grantedAccess); end
        next_cycle();
        next_cycle(); rw_c[2] = 1'b0; resetn = 1'b0; sample();
        checks++; if (memWriteEnable !== 1'b1) begin errors++; $display("[TB] FAIL rmw_write_cycle: got %b expected 1", memWriteEnable); end
        next_cycle(); resetn = 1'b1; req = 4'b1110; sample();
        checks++; if ({grantedAccess, busy, memWriteEnable, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0})
            begin errors++; $display("[TB] FAIL rmw_after_reset: got g=%b busy=%b we=%b owner=%0d expected 0000/0/0/0", grantedAccess, busy, memWriteEnable, owner); end
        next_cycle(); sample();
        checks++; if (grantedAccess !== 4'b0010) begin errors++; $display("[TB] FAIL rmw_ptr_cleared: got %b expected 0010", grantedAccess); end
        req = '0; rw_c = '1;
        next_cycle(); next_cycle();
    endtask

    task automatic test_random();
        logic [N-1:0]  exp_g;
        logic [AW-1:0] exp_a;
        logic          exp_rw, exp_we;
        logic [DW-1:0] exp_d;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            next_cycle();
            resetn = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                req[i]     = req[i] ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 25);
                addr_c[i]  = AW'($urandom);
                rw_c[i]    = ($urandom_range(0, 9) < 7);
                wdata_c[i] = $urandom;
            end
            sample();
            exp_g  = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
            exp_a  = (m_busy != 0) ? addr_c[m_owner] : '0;
            exp_rw = (m_busy != 0) ? rw_c[m_owner] : 1'b1;
            exp_d  = (m_busy != 0) ? wdata_c[m_owner] : '0;
            exp_we = (m_busy != 0) && req[m_owner] && !rw_c[m_owner];
            checks++; if (grantedAccess !== exp_g) begin errors++; $display("[TB] FAIL rand_grant cycle %0d: got %b expected %b", c, grantedAccess, exp_g); end
            checks++; if ({busy, owner, timeoutPulse} !== {m_busy[0], m_owner[1:0], m_tpulse[0]})
                begin errors++; $display("[TB] FAIL rand_status cycle %0d: got busy=%b owner=%0d p=%b expected %0d/%0d/%0d", c, busy, owner, timeoutPulse, m_busy, m_owner, m_tpulse); end
            checks++; if ({memAddress, memReadWrite, memWriteEnable, memWriteData} !== {exp_a, exp_rw, exp_we, exp_d})
                begin errors++; $display("[TB] FAIL rand_memport cycle %0d: got a=%h rw=%b we=%b d=%h expected %h/%b/%b/%h", c, memAddress, memReadWrite, memWriteEnable, memWriteData, exp_a, exp_rw, exp_we, exp_d); end
        end
        resetn = 1'b1;
        req = '0;
        next_cycle(); next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        req    = '0;
        rw_c   = '1;
        for (int i = 0; i < N; i++) begin
            addr_c[i]  = '0;
            wdata_c[i] = '0;
        end
        test_reset();
        test_single_client();
        test_atomic_increment();
        test_round_robin_all();
        test_no_preempt();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter_rr.md
Name: memory_arbiter_rr

Overview:
- Round-robin arbiter that shares one single-port synchronous memory (1-cycle read latency) between NUM_CLIENTS requesters.
- Each requester uses the request/grant protocol of the memory clients:
  - raise requestingMemory;
  - wait for grantedAccess;
  - read on the cycle after grant;
  - optionally write back;
  - drop the request.
- The arbiter registers the grant, muxes the owner's address, readWrite and write data onto the memory port, and releases the port when the owner drops its request or exceeds a hold limit.
- Memory read data fans out directly to all clients outside this block.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 32, memory data width.
- MAX_HOLD, 16, max cycles a grant may be held; 0 disables timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- requestingMemory  in  NUM_CLIENTS  per-client request, bit i = client i
- clientAddress  in  NUM_CLIENTS*ADDR_WIDTH  client i address at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- clientReadWrite  in  NUM_CLIENTS  per-client direction, 1=read, 0=write
- clientWriteData  in  NUM_CLIENTS*DATA_WIDTH  client i write data, sliced as for clientAddress
- grantedAccess  out  NUM_CLIENTS  registered one-hot grant
- memAddress  out  ADDR_WIDTH  address to memory
- memReadWrite  out  1  direction to memory, 1=read
- memWriteEnable  out  1  write strobe to memory
- memWriteData  out  DATA_WIDTH  write data to memory
- busy  out  1  high while a grant is active
- owner  out  clog2(NUM_CLIENTS)  index of current/last owner
- timeoutPulse  out  1  one-cycle pulse on forced revoke

Behaviour:
Reset (resetn=0 at posedge, any state, including mid-grant):
- state=IDLE, grantedAccess=0, busy=0, owner=0, priority pointer ptr=0, hold counter=0, timeoutPulse=0.

State IDLE:
- If any request bit is set, select the first set bit searching ptr, ptr+1, ... wrapping modulo NUM_CLIENTS.
- Next edge: grantedAccess=onehot(sel), owner=sel, busy=1, hold counter=0, state=BUSY.
- If no request is set, remain in IDLE.
- Arbitration adds exactly 1 cycle: request seen in cycle T gives grant visible in cycle T+1.

State BUSY:
- The hold counter increments each cycle.
- If requestingMemory[owner]==0: next edge grantedAccess=0, busy=0, ptr=(owner+1) mod NUM_CLIENTS, state=IDLE.
- Else if MAX_HOLD!=0 and the hold counter reaches MAX_HOLD-1: same release actions, plus timeoutPulse=1 for one cycle.
- Requests from other clients never pre-empt the owner.
- The minimum gap between consecutive grants is 1 IDLE cycle, with grant low.

Memory port (combinational from the registered owner and busy):
- busy=1: memAddress=clientAddress[owner], memReadWrite=clientReadWrite[owner], memWriteData=clientWriteData[owner], memWriteEnable = requestingMemory[owner] & ~clientReadWrite[owner].
- busy=0: memAddress=0, memReadWrite=1, memWriteData=0, memWriteEnable=0.

Fairness:
- A continuously requesting client waits at most NUM_CLIENTS-1 grant tenures.
- With all clients requesting, the grant order is 0,1,2,3,0,...

Simultaneous events:
- A request rising in the same cycle the owner releases is not seen until the following IDLE cycle.
- The releasing client may re-request immediately; it is then lowest priority.

Client-protocol timing (grant at cycle G):
- G: read address presented.
- G+1: client samples read data and drives readWrite=0.
- G+2: memWriteEnable=1.
- G+3: request low; grant still high, no write.
- G+4: IDLE.

Width rules:
- The hold counter is clog2(MAX_HOLD)+1 bits and saturates (never wraps).
- ptr and owner wrap modulo NUM_CLIENTS; this also holds for non-power-of-2 client counts.

Test Plan:
1. Single client 2 requests at cycle 5, address 8'h18, readWrite=1 → grantedAccess=4'b0100 at cycle 6; memAddress=8'h18, memWriteEnable=0; release 1 cycle after the request drops; ptr=3.
2. Atomic increment: memory[8'h18]=41; client 0 does read, then write of 42 at G+2 → memWriteEnable high exactly 1 cycle with memWriteData=42; memory reads back 42.
3. All 4 clients request continuously, each holding 3 cycles → grant order 0,1,2,3,0; each grant is followed by exactly one IDLE cycle with grantedAccess=0.
4. Clients 1 and 3 request while client 1 owns, client 3 already waiting → after client 1 releases, client 3 is granted before client 1's re-request; then client 1.
5. Client 0 holds its request for 40 cycles with MAX_HOLD=16 → grant drops after 16 busy cycles; timeoutPulse high 1 cycle; ptr=1; client 1 request is then granted.
6. resetn=0 for 1 cycle during client 2's write cycle → next cycle grantedAccess=0, busy=0, memWriteEnable=0, owner=0; next arbitration starts from ptr=0.
